line_feeder: RTL

LINE_FEEDER -- requirements
Module: line_feeder

---
 rtl/line_feeder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/line_feeder.sv
// line_feeder: buffers one square 8-bit image arriving as 32-bit AXI-Stream
// beats, then replays it as 3-pixel windows over five vertically adjacent
// rows, one strip of STRIP output rows at a time, with zero padding at the
// image borders.
module line_feeder #(
   parameter int IMG_W = 48,
   parameter int STRIP = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [23:0] o_pe_1_row,
   output logic [23:0] o_pe_2_row,
   output logic [23:0] o_pe_3_row,
   output logic [23:0] o_pe_4_row,
   output logic [23:0] o_pe_5_row,
   output logic        o_pe_valid,
   output logic        o_img_row_done,
   output logic        o_send_flg,
   output logic        o_err
);

   localparam int N_BEATS  = IMG_W * IMG_W / 4;
   localparam int N_STRIPS = IMG_W / STRIP;
   localparam int BW       = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int SW       = (N_STRIPS > 1) ? $clog2(N_STRIPS) : 1;

   localparam logic [1:0] S_LOAD    = 2'd0;
   localparam logic [1:0] S_STREAM  = 2'd1;
   localparam logic [1:0] S_ROWDONE = 2'd2;
   localparam logic [1:0] S_SEND    = 2'd3;

   // Image buffer: one 32-bit word per beat, row-major, four pixels per word.
   logic [31:0]      r_mem [N_BEATS];

   logic [1:0]       r_state;
   logic [BW-1:0]    r_beat;
   logic [SW-1:0]    r_strip;
   logic [CW-1:0]    r_col;
   logic             r_pe_valid;
   logic             r_row_done;
   logic             r_send_flg;
   logic             r_err;
   logic [4:0][23:0] r_pe_row;
   logic [4:0][23:0] w_win;
   logic             w_beat_acc;

   // Ready is withheld while rst is held so no beat is taken during reset.
   assign s_axis_tready = (r_state == S_LOAD) && !rst;
   assign w_beat_acc    = s_axis_tvalid && s_axis_tready;

   // Pixel fetch with zero padding outside the image.
   function automatic logic [7:0] f_pix(input int row, input int col);
      int            w_addr;
      logic [BW-1:0] w_word;
      logic [1:0]    w_lane;
      f_pix = 8'd0;
      if (row >= 0 && row < IMG_W && col >= 0 && col < IMG_W) begin
         w_addr = row * IMG_W + col;
         w_word = w_addr[BW+1:2];
         w_lane = w_addr[1:0];
         f_pix  = r_mem[w_word][{w_lane, 3'b000} +: 8];
      end
   endfunction

   // Window k of strip s looks at image row STRIP*s + k - 2 (k = 1..5).
   for (genvar gi = 0; gi < 5; gi++) begin : g_win
      int w_row;
      assign w_row     = STRIP * int'(r_strip) + gi - 1;
      assign w_win[gi] = {f_pix(w_row, int'(r_col) - 1),
                          f_pix(w_row, int'(r_col)),
                          f_pix(w_row, int'(r_col) + 1)};
   end

   // Store each accepted beat at its word address; the buffer is never cleared.
   always_ff @(posedge clk) begin
      if (w_beat_acc) r_mem[r_beat] <= s_axis_tdata;
   end

   // Window registers update only while streaming, so they hold otherwise.
   always_ff @(posedge clk) begin
      if (rst)                       r_pe_row <= '0;
      else if (r_state == S_STREAM)  r_pe_row <= w_win;
   end

   // Sequencer: load beats, stream strips, then flag the end of the image.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_LOAD;
         r_beat     <= '0;
         r_strip    <= '0;
         r_col      <= '0;
         r_pe_valid <= 1'b0;
         r_row_done <= 1'b0;
         r_send_flg <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // Strobes are registered from the state, one cycle behind it.
         r_pe_valid <= (r_state == S_STREAM);
         r_row_done <= (r_state == S_ROWDONE);
         r_send_flg <= (r_state == S_SEND) && !r_send_flg;
         case (r_state)
            S_LOAD: begin
               if (w_beat_acc) begin
                  if (r_beat == BW'(N_BEATS - 1)) begin
                     // Missing tlast on the final beat is flagged but the image is kept.
                     if (!s_axis_tlast) r_err <= 1'b1;
                     r_beat  <= '0;
                     r_strip <= '0;
                     r_col   <= '0;
                     r_state <= S_STREAM;
                  end else if (s_axis_tlast) begin
                     // Early tlast: discard the partial image and start over.
                     r_err  <= 1'b1;
                     r_beat <= '0;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (r_col == CW'(IMG_W - 1)) begin
                  r_col   <= '0;
                  r_state <= S_ROWDONE;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            S_ROWDONE: begin
               if (r_strip == SW'(N_STRIPS - 1)) begin
                  r_state <= S_SEND;
               end else begin
                  r_strip <= r_strip + 1'b1;
                  r_col   <= '0;
                  r_state <= S_STREAM;
               end
            end
            S_SEND: begin
               // Stay one extra cycle so the send pulse sits after the last row-done.
               if (r_send_flg) begin
                  r_beat  <= '0;
                  r_state <= S_LOAD;
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign o_pe_1_row     = r_pe_row[0];
   assign o_pe_2_row     = r_pe_row[1];
   assign o_pe_3_row     = r_pe_row[2];
   assign o_pe_4_row     = r_pe_row[3];
   assign o_pe_5_row     = r_pe_row[4];
   assign o_pe_valid     = r_pe_valid;
   assign o_img_row_done = r_row_done;
   assign o_send_flg     = r_send_flg;
   assign o_err          = r_err;

endmodule
